// File: rtl/pipe_scheduler.sv
// Pipe obstacle sequencer for Flappy: scrolls two pipes, respawns them with an
// LFSR-derived gap height, tracks which pipe the bird faces and keeps score.
module pipe_scheduler #(
  parameter int SCREEN_W     = 640,
  parameter int PIPE_W       = 80,
  parameter int PIPE_SPACING = 320,
  parameter int SPEED        = 2,
  parameter int BIRD_X       = 100,
  parameter int GAP_MIN      = 40
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Lose,
  output logic [9:0] X_Edge,
  output logic [9:0] Y_Edge,
  output logic [9:0] X_Edge_Next,
  output logic [9:0] Y_Edge_Next,
  output logic [7:0] Score,
  output logic       Scored,
  output logic       Q_Idle,
  output logic       Q_Run,
  output logic       Q_Over
);

  typedef enum logic [1:0] {
    QIDLE = 2'd0,
    QRUN  = 2'd1,
    QOVER = 2'd2
  } state_t;

  localparam logic [9:0]  X0_INIT  = 10'(SCREEN_W);
  localparam logic [9:0]  X1_INIT  = 10'(SCREEN_W + PIPE_SPACING);
  localparam logic [9:0]  SPC10    = 10'(PIPE_SPACING);
  localparam logic [9:0]  SPD10    = 10'(SPEED);
  localparam logic [9:0]  GAP10    = 10'(GAP_MIN);
  localparam logic [10:0] PW11     = 11'(PIPE_W);
  localparam logic [10:0] BX11     = 11'(BIRD_X);
  localparam logic [15:0] SEED     = 16'hACE1;

  state_t            state_q, state_d;
  logic [1:0][9:0]   px_q, px_d;
  logic [1:0][9:0]   py_q, py_d;
  logic [1:0][9:0]   mv;
  logic [1:0]        resp;
  logic              cur_q, cur_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [7:0]        score_q, score_d;
  logic              scored_q, scored_d;
  logic [10:0]       right_edge;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      resp[i] = (px_q[i] < SPD10);
      mv[i]   = resp[i] ? px_q[i] : (px_q[i] - SPD10);
    end
    // Right edge in 11 bits so a pipe parked near 1023 cannot wrap below BIRD_X.
    right_edge = {1'b0, mv[cur_q]} + PW11;
  end

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    cur_d    = cur_q;
    score_d  = score_q;
    scored_d = 1'b0;

    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (lfsr_d == 16'h0000) lfsr_d = SEED;

    case (state_q)
      QIDLE: begin
        if (Start) begin
          state_d = QRUN;
          py_d[0] = GAP10 + {2'b00, lfsr_q[7:0]};
          py_d[1] = GAP10 + {2'b00, lfsr_q[15:8]};
          score_d = 8'd0;
        end
      end
      QRUN: begin
        if (Lose) begin
          state_d = QOVER;
        end else if (Tick) begin
          for (int i = 0; i < 2; i++) begin
            px_d[i] = resp[i] ? (mv[1-i] + SPC10) : mv[i];
            py_d[i] = resp[i] ? (GAP10 + {2'b00, lfsr_q[7:0]}) : py_q[i];
          end
          if (right_edge < BX11) begin
            cur_d    = ~cur_q;
            scored_d = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end
        end
      end
      QOVER: begin
        if (Ack) begin
          state_d = QIDLE;
          px_d    = {X1_INIT, X0_INIT};
          py_d    = {GAP10, GAP10};
          cur_d   = 1'b0;
        end
      end
      default: begin
        state_d = QIDLE;
        px_d    = {X1_INIT, X0_INIT};
        py_d    = {GAP10, GAP10};
        cur_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= QIDLE;
      px_q     <= {X1_INIT, X0_INIT};
      py_q     <= {GAP10, GAP10};
      cur_q    <= 1'b0;
      lfsr_q   <= SEED;
      score_q  <= 8'd0;
      scored_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      cur_q    <= cur_d;
      lfsr_q   <= lfsr_d;
      score_q  <= score_d;
      scored_q <= scored_d;
    end
  end

  assign X_Edge      = cur_q ? px_q[1] : px_q[0];
  assign Y_Edge      = cur_q ? py_q[1] : py_q[0];
  assign X_Edge_Next = cur_q ? px_q[0] : px_q[1];
  assign Y_Edge_Next = cur_q ? py_q[0] : py_q[1];
  assign Score       = score_q;
  assign Scored      = scored_q;
  assign Q_Idle      = (state_q == QIDLE);
  assign Q_Run       = (state_q == QRUN);
  assign Q_Over      = (state_q == QOVER);

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Sequencer for the two on-screen pipe obstacles of the Flappy game. Owns pipe positions, scrolls them left on each frame tick, respawns a pipe at the right with a pseudo-random gap height once it leaves the screen, and keeps score. It presents the current pipe's left X edge and gap top Y edge to the collision checker. It consumes the checker's lose indication to freeze play.

## Interface
- SCREEN_W, 640: X where pipe 0 starts; pipe 1 starts at SCREEN_W+PIPE_SPACING.
- PIPE_W, 80: pipe width in pixels. Must match the checker's fixed width.
- PIPE_SPACING, 320: X distance between pipe left edges.
- SPEED, 2: pixels moved per Tick.
- BIRD_X, 100: fixed bird X, used for scoring.
- GAP_MIN, 40: minimum gap top Y.

Ports:
- Clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- Tick  in  1  one-cycle frame strobe.
- Start  in  1  begin a game; honoured only in QIdle.
- Ack  in  1  acknowledge game over; honoured only in QOver.
- Lose  in  1  collision indication from the checker; level, sampled in QRun.
- X_Edge  out  10  left edge of the current pipe.
- Y_Edge  out  10  gap top of the current pipe.
- X_Edge_Next  out  10  left edge of the other pipe, for drawing.
- Y_Edge_Next  out  10  gap top of the other pipe.
- Score  out  8  pipes passed; saturates at 255.
- Scored  out  1  one-cycle pulse when Score increments.
- Q_Idle, Q_Run, Q_Over  out  1 each  one-hot state flags.

## Operation
- State machine has three states: QIdle, QRun, QOver.
  - QIdle holds the initial layout. Start moves to QRun.
  - QRun: Lose moves to QOver, else process Tick.
  - QOver freezes everything. Ack moves to QIdle.
  - Any illegal encoding goes to QIdle.
- Pipe registers:
  - Each pipe i has px[i] (10-bit) and py[i] (10-bit). A 1-bit cur selects the current pipe.
  - X_Edge/Y_Edge = pipe[cur]; the *_Next outputs = pipe[~cur].
- Initial layout, loaded on reset and on entry to QIdle:
  - px0=SCREEN_W, px1=SCREEN_W+PIPE_SPACING.
  - py0=py1=GAP_MIN, cur=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset.
  - Advances every clock in all states; never loads zero.
- Start in QIdle:
  - py0 = GAP_MIN + lfsr[7:0] and py1 = GAP_MIN + lfsr[15:8], zero-extended to 10 bits.
  - Score cleared. Positions stay at the initial layout.
- Tick in QRun without Lose. All updates below happen in the same cycle.
  - Move: each px[i] -= SPEED, unless px[i] < SPEED.
  - Respawn when px[i] < SPEED:
    - px[i] = (post-move px of the other pipe) + PIPE_SPACING.
    - py[i] = GAP_MIN + lfsr[7:0].
  - Score: if (px[cur] post-move) + PIPE_W < BIRD_X, compared in 11-bit unsigned:
    - Score increments, saturating at 255; Scored=1 for one cycle.
    - cur toggles.
- Gap range is 40..295, so gap bottom (Y+100) ≤ 395 < 480.
- Right-edge arithmetic is done in 11 bits, so 960+80 does not wrap.
- Score holds through QOver and QIdle until the next Start.

## Timing
- All outputs are registered and change on the Clk edge after the triggering input.
- Tick-to-X_Edge latency is 1 cycle; Scored coincides with the updated X_Edge and cur.
- Reset values:
  - Q_Idle=1, Q_Run=0, Q_Over=0.
  - X_Edge=640, X_Edge_Next=960, Y_Edge=Y_Edge_Next=40.
  - Score=0, Scored=0.
- Lose and Tick in the same QRun cycle: Lose wins; no move, no score.
- Start or Ack outside its state is ignored.
- Tick outside QRun is ignored.
- reset mid-game returns to the reset values on the next edge, regardless of state.
- A respawn and a score event on the same Tick both take effect.

## Test plan
- Reset then idle: assert reset 2 cycles, release, apply 10 Ticks without Start -> X_Edge=640, X_Edge_Next=960, Score=0, Q_Idle=1.
- Scroll: Start, then 1 Tick -> next cycle X_Edge=638, X_Edge_Next=958, Y_Edge in 40..295.
- Score: Start, then 231 Ticks -> pipe0 moves from 640 to 178 with no score. The 232nd Tick (176+80 < 100 is false) still does not score. Scored pulses exactly when px0+80 first drops below 100 (px0=18, Tick 311). Then Score=1, cur=1, X_Edge=pipe1.
- Respawn: continue until px0 < 2 -> px0 = px1(post-move) + 320, Y_Edge_Next updated, no wrap above 1023.
- Lose/Ack: assert Lose with Tick in the same cycle -> Q_Over=1, X_Edge unchanged. Ticks are ignored in QOver. Ack -> Q_Idle, initial layout restored, Score retained until Start.
- Saturation and mid-game reset: force Score to 255 via a long run, pass another pipe -> Score stays 255 and Scored still pulses. Assert reset in QRun -> all outputs return to their reset values the next cycle.
